// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates the single memory port between instruction fetch (IF) and
// load/store (LS), checks alignment before launching, runs the
// en_mem/W_R_mem handshake until done_mem (or a cycle-count timeout),
// then returns data or an error to the winning requester.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   if_req/if_addr         fetch request (always a word read, unsigned)
//   if_ack/if_err          one-cycle completion pulse and error flag to IF
//   ls_req/ls_we/ls_wordsize/ls_sign/ls_addr/ls_wdata
//                          load/store request and command
//   ls_ack/ls_err          one-cycle completion pulse and error flag to LS
//   rdata                  read data, valid with either ack
//   mem_addr/mem_wdata/wordsize_mem/sign_mem
//                          latched command presented to the memory controller
//   en_mem/W_R_mem         memory enable and direction (01 read, 10 write)
//   mem_rdata/done_mem/busy_mem/aligned_mem
//                          memory controller responses
//   grant_ls               high while LS owns the port
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic          if_err,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_wordsize,
    input  logic          ls_sign,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic          ls_err,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          en_mem,
    output logic [1:0]    W_R_mem,
    output logic [1:0]    wordsize_mem,
    output logic          sign_mem,
    input  logic          busy_mem,
    input  logic          done_mem,
    input  logic          aligned_mem,
    output logic          grant_ls
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [2:0] state_reg;
    logic [7:0] count_reg;
    logic       we_reg;
    logic       last_ls_reg;   // 1 = LS was served last

    logic pick_ls;
    logic finish;
    logic finish_err;

    // On contention the requester that was not served last wins;
    // a lone request always wins.
    assign pick_ls = ls_req & (~if_req | ~last_ls_reg);

    // A transaction ends either from CHECK (misaligned) or from ACCESS
    // (done or timeout). done_mem takes priority over the timeout.
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state_reg)
            ST_CHECK: begin
                if (!aligned_mem) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (done_mem) begin
                    finish = 1'b1;
                end else if (count_reg == TIMEOUT_CNT) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 8'd0;
            we_reg       <= 1'b0;
            last_ls_reg  <= 1'b0;
            if_ack       <= 1'b0;
            if_err       <= 1'b0;
            ls_ack       <= 1'b0;
            ls_err       <= 1'b0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            en_mem       <= 1'b0;
            W_R_mem      <= 2'b00;
            wordsize_mem <= 2'b00;
            sign_mem     <= 1'b0;
            grant_ls     <= 1'b0;
        end else begin
            // Acks are single-cycle pulses raised on the edge into RESP.
            if_ack <= finish & ~grant_ls;
            if_err <= finish & finish_err & ~grant_ls;
            ls_ack <= finish & grant_ls;
            ls_err <= finish & finish_err & grant_ls;

            if (finish) begin
                en_mem  <= 1'b0;
                W_R_mem <= 2'b00;
                // Successful completion returns memory data; any error returns 0.
                rdata   <= (state_reg == ST_ACCESS && done_mem) ? mem_rdata : '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        grant_ls <= pick_ls;
                        if (pick_ls) begin
                            mem_addr     <= ls_addr;
                            mem_wdata    <= ls_wdata;
                            wordsize_mem <= ls_wordsize;
                            sign_mem     <= ls_sign;
                            we_reg       <= ls_we;
                        end else begin
                            mem_addr     <= if_addr;
                            mem_wdata    <= '0;
                            wordsize_mem <= 2'b10;
                            sign_mem     <= 1'b0;
                            we_reg       <= 1'b0;
                        end
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (finish) begin
                        state_reg <= ST_RESP;
                    end else begin
                        en_mem    <= 1'b1;
                        W_R_mem   <= we_reg ? 2'b10 : 2'b01;
                        count_reg <= 8'd0;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (finish) begin
                        state_reg <= ST_RESP;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                ST_RESP: begin
                    last_ls_reg <= grant_ls;
                    if (busy_mem) begin
                        state_reg <= ST_RELEASE;
                    end else begin
                        grant_ls  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (!busy_mem) begin
                        grant_ls  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. A small memory responder answers en_mem
// after a programmable number of cycles; expected results come from the
// transaction-level rules (latencies, round-robin order, error outcomes).
// Cycle numbers below are edge indices: "cyc" holds the index of the most
// recent rising edge, and k is the edge that first samples a request.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_wordsize;
    logic        ls_sign;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        en_mem;
    logic [1:0]  W_R_mem;
    logic [1:0]  wordsize_mem;
    logic        sign_mem;
    logic        busy_mem;
    logic        done_mem;
    logic        aligned_mem;
    logic        grant_ls;

    int checks;
    int failures;
    int cyc;

    // responder controls (written by the main sequence only)
    int          resp_delay;
    logic [31:0] resp_data;
    bit          withhold;
    bit          noise;
    int          busy_hold;
    // responder state
    int          en_count;
    int          busy_left;
    int          busy_fall_cyc;

    // monitor state
    bit          en_prev;
    int          en_rise_cyc;
    int          en_len;
    int          en_rises;
    int          overlap_cnt;
    int          ack_total;
    logic [1:0]  wr_at_en;
    logic [1:0]  size_at_en;
    logic        sign_at_en;
    logic        grant_at_en;
    logic [31:0] addr_at_en;
    logic [31:0] wdata_at_en;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_wordsize(ls_wordsize), .ls_sign(ls_sign),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_err(ls_err),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .en_mem(en_mem), .W_R_mem(W_R_mem), .wordsize_mem(wordsize_mem), .sign_mem(sign_mem),
        .busy_mem(busy_mem), .done_mem(done_mem), .aligned_mem(aligned_mem), .grant_ls(grant_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Natural alignment of the presented command.
    assign aligned_mem = (wordsize_mem == 2'b10) ? (mem_addr[1:0] == 2'b00) :
                         (wordsize_mem == 2'b01) ? (mem_addr[0] == 1'b0) : 1'b1;

    // Memory responder: done_mem after resp_delay cycles of en_mem,
    // optional busy tail after done, optional random done noise when idle.
    initial begin
        done_mem = 1'b0; mem_rdata = '0; busy_mem = 1'b0;
        en_count = 0; busy_left = 0; busy_fall_cyc = -1;
        forever begin
            @(posedge clk); #1;
            done_mem = 1'b0;
            if (en_mem === 1'b1) begin
                if (!withhold && en_count == resp_delay) begin
                    done_mem  = 1'b1;
                    mem_rdata = resp_data;
                end
                en_count++;
            end else begin
                en_count = 0;
                if (noise) begin
                    done_mem  = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                end
            end
            if (en_mem === 1'b1 && done_mem) begin
                if (busy_hold > 0) begin
                    busy_mem  = 1'b1;
                    busy_left = busy_hold;
                end
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (busy_mem) begin
                busy_mem      = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (en_mem === 1'b1 && !en_prev) begin
            en_rise_cyc = cyc;
            en_len      = 0;
            en_rises++;
            wr_at_en    = W_R_mem;
            size_at_en  = wordsize_mem;
            sign_at_en  = sign_mem;
            grant_at_en = grant_ls;
            addr_at_en  = mem_addr;
            wdata_at_en = mem_wdata;
        end
        if (en_mem === 1'b1) en_len++;
        if (en_mem === 1'b1 && (if_ack === 1'b1 || ls_ack === 1'b1)) overlap_cnt++;
        if (if_ack === 1'b1 || ls_ack === 1'b1) ack_total++;
        en_prev = (en_mem === 1'b1);
    end

    // Raise one request, wait (bounded) for any ack, then drop the request.
    task automatic issue_and_wait(input bit is_ls, output int k, output int ack_c,
                                  output bit a_if, output bit a_ls, output bit e_if,
                                  output bit e_ls, output logic [31:0] rd);
        ack_c = -1; a_if = 0; a_ls = 0; e_if = 0; e_ls = 0; rd = '0;
        @(posedge clk); #1;
        k = cyc + 1;
        if (is_ls) ls_req = 1'b1; else if_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if_ack === 1'b1 || ls_ack === 1'b1) begin
                ack_c = cyc; a_if = if_ack; a_ls = ls_ack;
                e_if = if_err; e_ls = ls_err; rd = rdata;
                break;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] ctrl;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
        end
        @(negedge clk);
        ctrl = {if_ack, if_err, ls_ack, ls_err, en_mem, W_R_mem, wordsize_mem, sign_mem, grant_ls};
        checks++;
        if (ctrl !== 11'd0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0", ctrl);
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'd0) begin
            failures++; $display("FAIL reset_data: got %h %h %h expected 0", mem_addr, mem_wdata, rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset: ctrl=%b", ctrl);
    endtask

    task automatic test_if_alone();
        for (int t = 0; t < 4; t++) begin
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] rd;
            int n, k, ack_c, rb;
            bit a_if, a_ls, e_if, e_ls;
            addr = $urandom; addr[1:0] = 2'b00;
            data = $urandom;
            n = $urandom_range(0, TO - 1);
            if (t == 0) begin addr = 32'h100; data = 32'hDEADBEEF; n = 0; end
            noise = (t != 0);
            resp_delay = n; resp_data = data; if_addr = addr;
            ls_addr = $urandom;
            rb = en_rises;
            issue_and_wait(1'b0, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
            checks++;
            if (ack_c !== k + 2 + n) begin failures++; $display("FAIL if_ack_cycle: got %0d expected %0d", ack_c, k + 2 + n); end
            checks++;
            if ({a_if, a_ls, e_if} !== 3'b100) begin failures++; $display("FAIL if_ack_err: got %b expected 100", {a_if, a_ls, e_if}); end
            checks++;
            if (rd !== data) begin failures++; $display("FAIL if_rdata: got %h expected %h", rd, data); end
            checks++;
            if (en_rises !== rb + 1 || en_rise_cyc !== k + 1) begin
                failures++; $display("FAIL if_en_rise: got %0d (rises %0d) expected %0d", en_rise_cyc, en_rises - rb, k + 1);
            end
            checks++;
            if ({wr_at_en, size_at_en, sign_at_en, grant_at_en, addr_at_en} !== {2'b01, 2'b10, 1'b0, 1'b0, addr}) begin
                failures++; $display("FAIL if_cmd: got wr=%b sz=%b sg=%b g=%b a=%h expected 01 10 0 0 %h",
                                     wr_at_en, size_at_en, sign_at_en, grant_at_en, addr_at_en, addr);
            end
            $display("if_alone: addr=%h n=%0d ack@%0d rdata=%h", addr, n, ack_c, rd);
        end
        noise = 0;
    endtask

    task automatic test_ls_random();
        for (int t = 0; t < 6; t++) begin
            logic [31:0] addr, wd, data, rd;
            logic [1:0] sz, exp_wr;
            logic we, sg;
            int n, k, ack_c, rb;
            bit a_if, a_ls, e_if, e_ls;
            sz = 2'($urandom_range(0, 2));
            addr = $urandom;
            if (sz == 2'b10) addr[1:0] = 2'b00;
            if (sz == 2'b01) addr[0] = 1'b0;
            we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            wd = $urandom; data = $urandom;
            n = $urandom_range(0, TO - 1);
            exp_wr = we ? 2'b10 : 2'b01;
            noise = 1;
            resp_delay = n; resp_data = data;
            ls_addr = addr; ls_we = we; ls_wordsize = sz; ls_sign = sg; ls_wdata = wd;
            rb = en_rises;
            issue_and_wait(1'b1, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
            checks++;
            if (ack_c !== k + 2 + n) begin failures++; $display("FAIL ls_ack_cycle: got %0d expected %0d", ack_c, k + 2 + n); end
            checks++;
            if ({a_if, a_ls, e_ls} !== 3'b010) begin failures++; $display("FAIL ls_ack_err: got %b expected 010", {a_if, a_ls, e_ls}); end
            checks++;
            if (rd !== data) begin failures++; $display("FAIL ls_rdata: got %h expected %h", rd, data); end
            checks++;
            if (en_rises !== rb + 1 ||
                {wr_at_en, size_at_en, sign_at_en, grant_at_en, addr_at_en, wdata_at_en} !== {exp_wr, sz, sg, 1'b1, addr, wd}) begin
                failures++; $display("FAIL ls_cmd: got wr=%b sz=%b sg=%b g=%b a=%h wd=%h expected %b %b %b 1 %h %h",
                                     wr_at_en, size_at_en, sign_at_en, grant_at_en, addr_at_en, wdata_at_en,
                                     exp_wr, sz, sg, addr, wd);
            end
            $display("ls_random: we=%b sz=%b addr=%h n=%0d ack@%0d rdata=%h", we, sz, addr, n, ack_c, rd);
        end
        noise = 0;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd;
        logic [31:0] addr;
        int k, ack_c, rb, n;
        bit a_if, a_ls, e_if, e_ls;
        // half-word store at an odd address
        ls_addr = 32'h103; ls_we = 1'b1; ls_wordsize = 2'b01; ls_sign = 1'b0; ls_wdata = $urandom;
        rb = en_rises;
        issue_and_wait(1'b1, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
        checks++;
        if (ack_c !== k + 1 || {a_ls, e_ls, a_if} !== 3'b110) begin
            failures++; $display("FAIL ls_misaligned: got ack@%0d flags=%b expected ack@%0d flags=110", ack_c, {a_ls, e_ls, a_if}, k + 1);
        end
        @(negedge clk);
        checks++;
        if (en_rises !== rb) begin failures++; $display("FAIL ls_misaligned_en: got %0d accesses expected 0", en_rises - rb); end
        $display("misaligned: ls half @103 ack@%0d err=%b", ack_c, e_ls);
        // word fetch at a non-word address
        addr = $urandom; addr[1:0] = 2'($urandom_range(1, 3));
        if_addr = addr;
        rb = en_rises;
        issue_and_wait(1'b0, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
        checks++;
        if (ack_c !== k + 1 || {a_if, e_if, a_ls} !== 3'b110 || en_rises !== rb) begin
            failures++; $display("FAIL if_misaligned: got ack@%0d flags=%b accesses=%0d expected ack@%0d flags=110 accesses=0",
                                 ack_c, {a_if, e_if, a_ls}, en_rises - rb, k + 1);
        end
        $display("misaligned: if @%h ack@%0d err=%b", addr, ack_c, e_if);
        // a byte at an odd address is always aligned
        n = $urandom_range(0, TO - 1);
        resp_delay = n; resp_data = $urandom;
        ls_addr = 32'h103; ls_we = 1'b0; ls_wordsize = 2'b00; ls_sign = 1'b1;
        issue_and_wait(1'b1, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
        checks++;
        if (ack_c !== k + 2 + n || {a_ls, e_ls} !== 2'b10 || rd !== resp_data) begin
            failures++; $display("FAIL ls_byte_odd: got ack@%0d flags=%b rdata=%h expected ack@%0d flags=10 rdata=%h",
                                 ack_c, {a_ls, e_ls}, rd, k + 2 + n, resp_data);
        end
        $display("misaligned: ls byte @103 ack@%0d err=%b", ack_c, e_ls);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int k, ack_c;
        bit a_if, a_ls, e_if, e_ls;
        withhold = 1;
        ls_addr = 32'h200; ls_we = 1'b0; ls_wordsize = 2'b10; ls_sign = 1'b0;
        issue_and_wait(1'b1, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
        withhold = 0;
        checks++;
        if (ack_c !== k + 2 + TO || ack_c !== en_rise_cyc + TO + 1) begin
            failures++; $display("FAIL timeout_cycle: got ack@%0d en@%0d expected ack@%0d", ack_c, en_rise_cyc, k + 2 + TO);
        end
        checks++;
        if (en_len !== TO + 1) begin failures++; $display("FAIL timeout_en_len: got %0d expected %0d", en_len, TO + 1); end
        checks++;
        if ({a_ls, e_ls} !== 2'b11 || rd !== 32'd0) begin
            failures++; $display("FAIL timeout_resp: got flags=%b rdata=%h expected 11 00000000", {a_ls, e_ls}, rd);
        end
        $display("timeout: ack@%0d en_len=%0d err=%b rdata=%h", ack_c, en_len, e_ls, rd);
    endtask

    task automatic test_round_robin();
        logic [31:0] ia, la, data;
        bit last_ls, exp_ls, lw;
        int n, k, ack_c, rb;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        noise = 1;
        ia = $urandom; ia[1:0] = 2'b00;
        la = $urandom; la[1:0] = 2'b00;
        lw = 1'($urandom_range(0, 1));
        if_addr = ia; ls_addr = la; ls_we = lw; ls_wordsize = 2'b10; ls_sign = 1'b0; ls_wdata = $urandom;
        n = $urandom_range(0, TO - 1); data = $urandom;
        resp_delay = n; resp_data = data;
        last_ls = 0;
        @(posedge clk); #1;
        k = cyc + 1;
        if_req = 1'b1; ls_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_ls = !last_ls;
            rb = en_rises;
            ack_c = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (if_ack === 1'b1 || ls_ack === 1'b1) begin ack_c = cyc; break; end
            end
            checks++;
            if ({if_ack, ls_ack} !== {!exp_ls, exp_ls} || ack_c !== k + 2 + n) begin
                failures++; $display("FAIL rr_winner_%0d: got acks=%b @%0d expected %b @%0d",
                                     t, {if_ack, ls_ack}, ack_c, {!exp_ls, exp_ls}, k + 2 + n);
            end
            checks++;
            if (rdata !== data || en_rises !== rb + 1 || en_rise_cyc !== k + 1 ||
                addr_at_en !== (exp_ls ? la : ia) || wr_at_en !== ((exp_ls && lw) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL rr_txn_%0d: got rdata=%h en@%0d addr=%h wr=%b expected %h en@%0d addr=%h",
                                     t, rdata, en_rise_cyc, addr_at_en, wr_at_en, data, k + 1, exp_ls ? la : ia);
            end
            $display("round_robin: txn=%0d winner=%s ack@%0d rdata=%h", t, exp_ls ? "LS" : "IF", ack_c, rdata);
            last_ls = exp_ls;
            // the served requester immediately presents a new command
            if (exp_ls) begin
                la = $urandom; la[1:0] = 2'b00; lw = 1'($urandom_range(0, 1));
                ls_addr = la; ls_we = lw;
            end else begin
                ia = $urandom; ia[1:0] = 2'b00;
                if_addr = ia;
            end
            n = $urandom_range(0, TO - 1); data = $urandom;
            resp_delay = n; resp_data = data;
            k = ack_c + 2;
        end
        if_req = 1'b0; ls_req = 1'b0;
        noise = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_busy();
        logic [31:0] ia, la, data, rd, idle_addr;
        int k, ack_a, ack_c, n;
        bit a_if, a_ls, e_if, e_ls;
        busy_hold = 3;
        ia = $urandom; ia[1:0] = 2'b00;
        la = ia ^ 32'h40;
        if_addr = ia;
        resp_delay = $urandom_range(0, TO - 1); resp_data = $urandom;
        issue_and_wait(1'b0, k, ack_a, a_if, a_ls, e_if, e_ls, rd);
        checks++;
        if ({a_if, e_if} !== 2'b10) begin failures++; $display("FAIL busy_first: got %b expected 10", {a_if, e_if}); end
        // LS waits while memory is still busy
        n = $urandom_range(0, TO - 1); data = $urandom;
        resp_delay = n; resp_data = data;
        ls_addr = la; ls_we = 1'b0; ls_wordsize = 2'b10; ls_sign = 1'b0;
        ls_req = 1'b1;
        busy_hold = 0;
        idle_addr = '0;
        ack_c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_fall_cyc > ack_a && cyc == busy_fall_cyc + 1) idle_addr = mem_addr;
            if (if_ack === 1'b1 || ls_ack === 1'b1) begin ack_c = cyc; break; end
        end
        ls_req = 1'b0;
        checks++;
        if (en_rise_cyc !== busy_fall_cyc + 3 || idle_addr !== ia) begin
            failures++; $display("FAIL busy_hold_grant: got en@%0d addr_before=%h expected en@%0d addr_before=%h",
                                 en_rise_cyc, idle_addr, busy_fall_cyc + 3, ia);
        end
        checks++;
        if (ack_c !== en_rise_cyc + 1 + n || ls_ack !== 1'b1 || rdata !== data) begin
            failures++; $display("FAIL busy_second: got ack@%0d ls_ack=%b rdata=%h expected ack@%0d 1 %h",
                                 ack_c, ls_ack, rdata, en_rise_cyc + 1 + n, data);
        end
        $display("busy: busy_fall@%0d ls en@%0d ack@%0d rdata=%h", busy_fall_cyc, en_rise_cyc, ack_c, rdata);
    endtask

    task automatic test_reset_in_access();
        logic [10:0] ctrl;
        logic [31:0] rd;
        int acks_before, k, ack_c, n;
        bit a_if, a_ls, e_if, e_ls;
        withhold = 1;
        ls_addr = 32'h300; ls_we = 1'b1; ls_wordsize = 2'b10; ls_sign = 1'b0; ls_wdata = $urandom;
        @(posedge clk); #1;
        ls_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_mem === 1'b1) break;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; ls_req = 1'b0;
        acks_before = ack_total;
        @(negedge clk);
        @(negedge clk);
        ctrl = {if_ack, if_err, ls_ack, ls_err, en_mem, W_R_mem, wordsize_mem, sign_mem, grant_ls};
        checks++;
        if (ctrl !== 11'd0 || {mem_addr, mem_wdata, rdata} !== 96'd0) begin
            failures++; $display("FAIL reset_in_access: got ctrl=%b addr=%h wdata=%h rdata=%h expected all 0",
                                 ctrl, mem_addr, mem_wdata, rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        withhold = 0;
        repeat (TO + 4) @(negedge clk);
        checks++;
        if (ack_total !== acks_before) begin
            failures++; $display("FAIL reset_no_ack: got %0d acks expected 0", ack_total - acks_before);
        end
        $display("reset_in_access: ctrl=%b stray_acks=%0d", ctrl, ack_total - acks_before);
        // reissued request completes normally
        n = $urandom_range(0, TO - 1);
        resp_delay = n; resp_data = $urandom;
        issue_and_wait(1'b1, k, ack_c, a_if, a_ls, e_if, e_ls, rd);
        checks++;
        if (ack_c !== k + 2 + n || {a_ls, e_ls, a_if} !== 3'b100 || wr_at_en !== 2'b10 || addr_at_en !== 32'h300) begin
            failures++; $display("FAIL reset_reissue: got ack@%0d flags=%b wr=%b addr=%h expected ack@%0d 100 10 00000300",
                                 ack_c, {a_ls, e_ls, a_if}, wr_at_en, addr_at_en, k + 2 + n);
        end
        $display("reset_in_access: reissue ack@%0d", ack_c);
    endtask

    task automatic test_invariants();
        checks++;
        if (overlap_cnt !== 0) begin
            failures++; $display("FAIL en_ack_overlap: got %0d cycles expected 0", overlap_cnt);
        end
        $display("invariants: en/ack overlap cycles=%0d", overlap_cnt);
    endtask

    initial begin
        checks = 0; failures = 0;
        en_prev = 0; en_rise_cyc = -1; en_len = 0; en_rises = 0; overlap_cnt = 0; ack_total = 0;
        resp_delay = 0; resp_data = '0; withhold = 0; noise = 0; busy_hold = 0;
        reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_addr = '0;
        ls_we = 1'b0; ls_wordsize = 2'b00; ls_sign = 1'b0; ls_addr = '0; ls_wdata = '0;
        test_reset();
        test_if_alone();
        test_ls_random();
        test_misaligned();
        test_timeout();
        test_round_robin();
        test_busy();
        test_reset_in_access();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
